// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared helpers for the stream demultiplexer: channel count and select decode
package demux_pkg;

  localparam int unsigned MAX_S  = 8;
  localparam int unsigned MAX_CH = 1 << MAX_S;

  function automatic int unsigned ch_count(input int unsigned s);
    return 1 << s;
  endfunction

  // Bits at or above ch_count(s) are never set; callers keep the low CH bits.
  function automatic logic [MAX_CH-1:0] onehot(input logic [MAX_S-1:0] sel, input int unsigned s);
    logic [MAX_CH-1:0] m;
    m = '0;
    if (32'(sel) < ch_count(s)) m[sel] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output holding register with valid/ready handshake
module demux_slot #(
  parameter int N = 2
)(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic         free
);

  logic         valid_q, valid_d;
  logic [N-1:0] data_q, data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Load wins over drain so a full slot can be emptied and refilled on one edge.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  assign free      = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/demux_stream.sv
// rtl/demux_stream.sv - registered valid/ready demultiplexer with broadcast to 2**S channels
module demux_stream
  import demux_pkg::*;
#(
  parameter  int N  = 2,
  parameter  int S  = 1,
  localparam int CH = int'(ch_count(S))
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          in_data,
  input  logic [S-1:0]          in_select,
  input  logic                  in_bcast,
  output logic [CH-1:0]         out_valid,
  input  logic [CH-1:0]         out_ready,
  output logic [CH-1:0][N-1:0]  out_data
);

  logic [MAX_CH-1:0] sel_oh;
  logic              unused_oh;
  logic [CH-1:0]     tgt;
  logic [CH-1:0]     free;
  logic [CH-1:0]     load;
  logic              fire;

  assign sel_oh    = onehot(MAX_S'(in_select), S);
  assign unused_oh = ^sel_oh;
  assign tgt       = in_bcast ? {CH{1'b1}} : sel_oh[CH-1:0];

  // All-or-nothing: every targeted slot must be free, so a broadcast never splits.
  assign in_ready = &(~tgt | free);
  assign fire     = in_valid && in_ready;
  assign load     = {CH{fire}} & tgt;

  for (genvar i = 0; i < CH; i++) begin : g_slot
    demux_slot #(.N(N)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load[i]),
      .load_data (in_data),
      .out_ready (out_ready[i]),
      .out_valid (out_valid[i]),
      .out_data  (out_data[i]),
      .free      (free[i])
    );
  end

endmodule

// File: tb/tb_demux_stream.sv
// tb/tb_demux_stream.sv - directed and soak stimulus against a per-channel queue scoreboard
`timescale 1ns/1ps
module tb_demux_stream;

  localparam int N  = 8;
  localparam int S  = 2;
  localparam int CH = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [N-1:0]         in_data;
  logic [S-1:0]         in_select;
  logic                 in_bcast;
  logic [CH-1:0]        out_valid;
  logic [CH-1:0]        out_ready;
  logic [CH-1:0][N-1:0] out_data;

  int checks   = 0;
  int failures = 0;

  typedef logic [N-1:0] beat_q_t [$];
  beat_q_t exp_q [CH];

  logic [CH-1:0] m_mask;
  logic          m_rdy;
  logic          acc;

  always #10 clk = ~clk;

  demux_stream #(.N(N), .S(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_select (in_select),
    .in_bcast  (in_bcast),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] d, input logic [S-1:0] sel, input logic bc);
    in_valid  = 1'b1;
    in_data   = d;
    in_select = sel;
    in_bcast  = bc;
  endtask

  task automatic idle;
    in_valid = 1'b0;
    in_bcast = 1'b0;
  endtask

  task automatic clear_model;
    for (int i = 0; i < CH; i++) exp_q[i].delete();
  endtask

  // Scoreboard: pops on each output handshake, pushes on each modelled acceptance.
  always @(negedge clk) begin
    if (!reset) begin
      m_mask = in_bcast ? {CH{1'b1}} : (CH'(1) << in_select);
      m_rdy  = 1'b1;
      for (int i = 0; i < CH; i++)
        if (m_mask[i] && exp_q[i].size() != 0 && !out_ready[i]) m_rdy = 1'b0;
      check("in_ready", 32'(in_ready), 32'(m_rdy));
      for (int i = 0; i < CH; i++) begin
        check($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(exp_q[i].size() != 0));
        if (out_valid[i] && exp_q[i].size() != 0) begin
          check($sformatf("out_data[%0d]", i), 32'(out_data[i]), 32'(exp_q[i][0]));
          if (out_ready[i]) void'(exp_q[i].pop_front());
        end
      end
      if (in_valid && m_rdy)
        for (int i = 0; i < CH; i++)
          if (m_mask[i]) exp_q[i].push_back(in_data);
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_select = '0;
    in_bcast  = 1'b0;
    out_ready = '1;
    #1;
    check("reset_valid", 32'(out_valid), 32'h0);
    check("reset_data", 32'(out_data), 32'h0);
    #4 reset = 1'b0;

    // Back-to-back beats to two channels.
    tick;
    drive(8'h01, 2'd0, 1'b0);
    #1 check("t1_ready_a", 32'(in_ready), 32'h1);
    tick;
    drive(8'h02, 2'd1, 1'b0);
    #1 check("t1_ready_b", 32'(in_ready), 32'h1);
    check("t1_valid_a", 32'(out_valid), 32'h1);
    check("t1_data_a", 32'(out_data[0]), 32'h01);
    tick;
    idle;
    #1 check("t1_valid_b", 32'(out_valid), 32'h2);
    check("t1_data_b", 32'(out_data[1]), 32'h02);
    tick;

    // Stall on channel 0, then drain and refill on one edge.
    out_ready = 4'b1110;
    drive(8'h03, 2'd0, 1'b0);
    tick;
    drive(8'h01, 2'd0, 1'b0);
    #1 check("t2_ready_stall", 32'(in_ready), 32'h0);
    tick;
    #1 check("t2_ready_stall2", 32'(in_ready), 32'h0);
    check("t2_hold_valid", 32'(out_valid[0]), 32'h1);
    check("t2_hold_data", 32'(out_data[0]), 32'h03);
    out_ready = 4'b1111;
    #1 check("t2_ready_open", 32'(in_ready), 32'h1);
    tick;
    idle;
    #1 check("t2_refill_valid", 32'(out_valid[0]), 32'h1);
    check("t2_refill_data", 32'(out_data[0]), 32'h01);
    tick;

    // A stalled channel does not block a different channel.
    out_ready = 4'b1110;
    drive(8'h0C, 2'd0, 1'b0);
    tick;
    drive(8'h0A, 2'd1, 1'b0);
    #1 check("t3_ready", 32'(in_ready), 32'h1);
    tick;
    idle;
    #1 check("t3_valid", 32'(out_valid[1:0]), 32'h3);
    check("t3_data1", 32'(out_data[1]), 32'h0A);
    out_ready = 4'b1111;
    tick;
    tick;

    // Broadcast blocked by one full stalled channel, then delivered everywhere.
    out_ready = 4'b1011;
    drive(8'h5A, 2'd2, 1'b0);
    tick;
    drive(8'hA5, 2'd0, 1'b1);
    #1 check("t4_ready_block", 32'(in_ready), 32'h0);
    tick;
    #1 check("t4_ready_block2", 32'(in_ready), 32'h0);
    check("t4_no_partial", 32'(out_valid), 32'h4);
    check("t4_ch2_data", 32'(out_data[2]), 32'h5A);
    out_ready = 4'b1111;
    #1 check("t4_ready_open", 32'(in_ready), 32'h1);
    tick;
    idle;
    #1 check("t4_bcast_valid", 32'(out_valid), 32'hF);
    check("t4_bcast_data", 32'(out_data), 32'hA5A5A5A5);
    tick;

    // Asynchronous reset with every channel full and stalled.
    out_ready = 4'b0000;
    for (int i = 0; i < CH; i++) begin
      drive(8'h10 + 8'(i), 2'(i), 1'b0);
      tick;
    end
    idle;
    #1 check("t5_full", 32'(out_valid), 32'hF);
    #1 reset = 1'b1;
    #1 check("t5_rst_valid", 32'(out_valid), 32'h0);
    check("t5_rst_data", 32'(out_data), 32'h0);
    clear_model;
    #1 reset = 1'b0;
    out_ready = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      tick;
      #1 check("t5_no_reappear", 32'(out_valid), 32'h0);
    end
    tick;

    // Random soak; the scoreboard checks every cycle.
    for (int c = 0; c < 400; c++) begin
      out_ready = 4'($urandom) | 4'($urandom);
      if (!in_valid && $urandom_range(0, 3) != 0)
        drive(8'($urandom), 2'($urandom), $urandom_range(0, 5) == 0);
      #14 acc = in_valid && in_ready;
      tick;
      if (acc) idle;
    end
    idle;
    out_ready = 4'b1111;
    repeat (3) tick;
    check("drain_valid", 32'(out_valid), 32'h0);
    for (int i = 0; i < CH; i++)
      check($sformatf("drain_q[%0d]", i), 32'(exp_q[i].size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
Registered, flow-controlled successor to the combinational DEMUX. It routes an N-bit input beat to one of 2**S output channels, or broadcasts it to all of them, using valid/ready handshakes on every side. Each output channel has a one-entry holding register, so back-pressure on one channel does not corrupt data on another. It sits between producer and consumer units in the CPU datapath wherever a result must be steered to one of several downstream stages.

Parameters:
N, 2, data width in bits (N >= 1)
S, 1, select width in bits; channel count CH = 2**S (S >= 1)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input beat present
in_ready  output  1  block can accept the beat presented this cycle
in_data  input  N  beat payload
in_select  input  S  destination channel index (ignored when in_bcast=1)
in_bcast  input  1  deliver beat to all CH channels
out_valid  output  CH  per-channel holding register full
out_ready  input  CH  per-channel consumer accepts
out_data  output  [CH-1:0][N-1:0]  per-channel payload, packed array, channel i at index i

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. While reset is high: out_valid=0 and out_data=0 for all channels.
- Reset mid-operation: all held beats are discarded. No beat is delivered after reset deasserts unless it is accepted anew.
- Target mask: T = in_bcast ? all-ones(CH) : onehot(in_select).
- Slot free this cycle: free[i] = !out_valid[i] || out_ready[i]. This allows drain and fill on the same edge.
- in_ready = AND over i of (!T[i] || free[i]).
  - in_ready is combinational from in_select, in_bcast, out_valid and out_ready.
  - in_ready never depends on in_valid.
  - Producers must hold in_select and in_bcast stable while in_valid=1.
- Accept: fire = in_valid && in_ready. Acceptance is all-or-nothing: a broadcast is loaded into every channel on the same edge or not at all. There is no partial broadcast.
- Per channel i, on each edge:
  - if fire && T[i]: out_valid[i] <= 1, out_data[i] <= in_data
  - else if out_ready[i]: out_valid[i] <= 0 (out_data[i] holds its value)
  - else: hold
- Latency: a beat accepted at edge k is visible on out_valid/out_data in the cycle after edge k (1 cycle).
- Throughput: 1 beat per cycle when the targeted consumers keep out_ready=1.
- Stall stability: while out_valid[i]=1 and out_ready[i]=0, out_data[i] must not change.
- Non-targeted channels are never modified by a fire.
- Ordering: per channel, beats leave in acceptance order. Beats on different channels are not ordered relative to each other.
- No combinational path from in_data to out_data. All out_* are registered.

Decomposition:
- Package demux_pkg:
  - function onehot(sel, S) returning a CH-bit mask
  - helper computing CH = 2**S
- Sub-module demux_slot (parameter N): one-entry holding register.
  - Ports: clk, reset, load, load_data, out_ready, out_valid, out_data, free.
  - Instantiated CH times by a generate loop.
  - The top level keeps only the mask, in_ready and fire logic.

Test Plan:
1. N=2, S=1, both out_ready=1. Send a=2'b01 sel=0, then a=2'b10 sel=1 on back-to-back cycles. Expect out_valid=2'b01 with out_data[0]=01 one cycle after the first edge, then out_valid=2'b10 with out_data[1]=10. in_ready stays 1 throughout.
2. Stall: out_ready[0]=0. Send 2'b11 to sel=0, then 2'b01 to sel=0. Expect the second beat to see in_ready=0 and out_data[0] to hold 11. Raise out_ready[0]: 11 drains, 01 is loaded on the same edge, and out_valid[0] stays 1.
3. Independence: out_ready[0]=0 with channel 0 full. Send 2'b10 to sel=1. Expect it accepted (in_ready=1) and out_valid=2'b11.
4. Broadcast, N=8, S=2: out_ready=4'b1011 with channel 2 full. Send 8'hA5 with in_bcast=1. Expect in_ready=0 and no channel loaded. Set out_ready[2]=1: all four channels show A5 next cycle, out_valid=4'b1111.
5. Reset mid-operation: with all channels full and stalled, pulse reset asynchronously between edges. Expect out_valid=0 and out_data=0 immediately, with no beat reappearing afterwards.
6. Random soak, N=8, S=2: random valid/ready/select/bcast against a scoreboard with one queue per channel. Expect no loss, no duplication, per-channel order preserved and stall stability held.
